// File: rtl/sine_phase_sequencer.sv
// Phase-accumulator sequencer for a quarter-wave sine ROM stage.
// Produces a programmable-rate sample strobe, a 9-bit phase index and the
// pre-decoded quadrant controls (ROM address, mirror, negate).
module sine_phase_sequencer #(
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_FTW = 32768
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             sync_clear,
    input  logic [DIV_W-1:0] div_in,
    input  logic [ACC_W-1:0] ftw_in,
    input  logic             ftw_valid,
    output logic             ftw_ready,
    output logic             sample_strobe,
    output logic [8:0]       phase_index,
    output logic [6:0]       lut_addr,
    output logic             mirror,
    output logic             negate,
    output logic             wrapped
);

    localparam int unsigned PH_W   = 9;
    localparam int unsigned ADDR_W = 7;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [ACC_W-1:0] acc;
    logic [DIV_W-1:0] cnt;
    logic [ACC_W-1:0] ftw_active;
    logic [ACC_W-1:0] ftw_pend;
    logic             pending;

    logic [DIV_W-1:0]  div_eff;
    logic              tick;
    logic [ACC_W:0]    sum;
    logic [PH_W-1:0]   phase_cur;
    logic [ADDR_W-1:0] lut_cur;
    logic              accept;
    logic              commit;
    logic              pending_next;

    // Run/stop state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= STOP;
        else        state <= state_next;
    end

    // Next-state logic: follow the run level
    always_comb begin
        state_next = state;
        case (state)
            STOP:    if (run)  state_next = RUN;
            RUN:     if (!run) state_next = STOP;
            default: state_next = STOP;
        endcase
    end

    // Divider tick, accumulator add, quadrant decode and handshake qualifiers
    always_comb begin
        div_eff      = (div_in == '0) ? DIV_W'(1) : div_in;
        tick         = (state == RUN) && run && (cnt >= (div_eff - DIV_W'(1)));
        sum          = {1'b0, acc} + {1'b0, ftw_active};
        phase_cur    = acc[ACC_W-1 -: PH_W];
        lut_cur      = phase_cur[7] ? ~phase_cur[ADDR_W-1:0] : phase_cur[ADDR_W-1:0];
        accept       = ftw_valid && !pending;
        commit       = pending && (sync_clear || tick);
        pending_next = pending ? !(sync_clear || tick) : accept;
    end

    // Datapath, tuning-word handshake and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc           <= '0;
            cnt           <= '0;
            ftw_active    <= ACC_W'(DEFAULT_FTW);
            ftw_pend      <= '0;
            pending       <= 1'b0;
            ftw_ready     <= 1'b0;
            sample_strobe <= 1'b0;
            phase_index   <= '0;
            lut_addr      <= '0;
            mirror        <= 1'b0;
            negate        <= 1'b0;
            wrapped       <= 1'b0;
        end else begin
            // New word lands only at a sample boundary or on a clear
            if (commit) ftw_active <= ftw_pend;
            if (accept) ftw_pend   <= ftw_in;
            pending   <= pending_next;
            ftw_ready <= !pending_next;

            if (sync_clear) begin
                // Clear wins over a coincident tick: no strobe, no add
                acc           <= '0;
                cnt           <= '0;
                sample_strobe <= 1'b0;
                phase_index   <= '0;
                lut_addr      <= '0;
                mirror        <= 1'b0;
                negate        <= 1'b0;
                wrapped       <= 1'b0;
            end else begin
                sample_strobe <= tick;
                wrapped       <= tick && sum[ACC_W];
                if (tick) begin
                    acc         <= sum[ACC_W-1:0];
                    phase_index <= phase_cur;
                    lut_addr    <= lut_cur;
                    mirror      <= phase_cur[7];
                    negate      <= phase_cur[8];
                end
                if ((state != RUN) || !run || tick) cnt <= '0;
                else                                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Directed self-checking bench for sine_phase_sequencer.
module tb_sine_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        sync_clear;
    logic [15:0] div_in;
    logic [23:0] ftw_in;
    logic        ftw_valid;
    logic        ftw_ready;
    logic        sample_strobe;
    logic [8:0]  phase_index;
    logic [6:0]  lut_addr;
    logic        mirror;
    logic        negate;
    logic        wrapped;

    int checks = 0;
    int errors = 0;

    sine_phase_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .sync_clear    (sync_clear),
        .div_in        (div_in),
        .ftw_in        (ftw_in),
        .ftw_valid     (ftw_valid),
        .ftw_ready     (ftw_ready),
        .sample_strobe (sample_strobe),
        .phase_index   (phase_index),
        .lut_addr      (lut_addr),
        .mirror        (mirror),
        .negate        (negate),
        .wrapped       (wrapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until a strobe is seen or the budget runs out
    task automatic wait_strobe(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_strobe && n < max);
        chk("strobe_seen", 32'(sample_strobe), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        run        = 1'b0;
        sync_clear = 1'b0;
        div_in     = 16'd1;
        ftw_in     = 24'd0;
        ftw_valid  = 1'b0;
        step(); step(); step();

        // Reset state
        chk("rst_strobe",  32'(sample_strobe), 32'd0);
        chk("rst_index",   32'(phase_index),   32'd0);
        chk("rst_lut",     32'(lut_addr),      32'd0);
        chk("rst_mirror",  32'(mirror),        32'd0);
        chk("rst_negate",  32'(negate),        32'd0);
        chk("rst_wrapped", 32'(wrapped),       32'd0);
        chk("rst_ready",   32'(ftw_ready),     32'd0);

        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(ftw_ready), 32'd1);
        chk("idle_no_strobe",  32'(sample_strobe), 32'd0);

        // Full period at div 1 with the default tuning word
        run = 1'b1;
        step();
        chk("lat_no_strobe", 32'(sample_strobe), 32'd0);
        step();
        chk("first_strobe", 32'(sample_strobe), 32'd1);
        chk("first_index",  32'(phase_index),   32'd0);
        for (int i = 1; i <= 512; i++) begin
            step();
            chk("p_strobe",  32'(sample_strobe), 32'd1);
            chk("p_index",   32'(phase_index),   32'(i % 512));
            chk("p_wrapped", 32'(wrapped),       (i == 511) ? 32'd1 : 32'd0);
            if (i == 128) begin
                chk("i128_lut",    32'(lut_addr), 32'd127);
                chk("i128_mirror", 32'(mirror),   32'd1);
                chk("i128_negate", 32'(negate),   32'd0);
            end
            if (i == 300) begin
                chk("i300_lut",    32'(lut_addr), 32'd44);
                chk("i300_mirror", 32'(mirror),   32'd0);
                chk("i300_negate", 32'(negate),   32'd1);
            end
            if (i == 450) begin
                chk("i450_lut",    32'(lut_addr), 32'd61);
                chk("i450_mirror", 32'(mirror),   32'd1);
                chk("i450_negate", 32'(negate),   32'd1);
            end
        end

        // Divider 5, then lower to 2 with cnt at 3
        div_in = 16'd5;
        wait_strobe(12, n);
        chk("div5_gap_a", 32'(n),           32'd5);
        chk("div5_idx_a", 32'(phase_index), 32'd1);
        wait_strobe(12, n);
        chk("div5_gap_b", 32'(n),           32'd5);
        chk("div5_idx_b", 32'(phase_index), 32'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("div5_quiet", 32'(sample_strobe), 32'd0);
            chk("div5_hold",  32'(phase_index),   32'd2);
        end
        div_in = 16'd2;
        wait_strobe(12, n);
        chk("div2_first_gap", 32'(n),           32'd1);
        chk("div2_idx_a",     32'(phase_index), 32'd3);
        wait_strobe(12, n);
        chk("div2_gap_b", 32'(n),           32'd2);
        chk("div2_idx_b", 32'(phase_index), 32'd4);
        wait_strobe(12, n);
        chk("div2_gap_c", 32'(n),           32'd2);
        chk("div2_idx_c", 32'(phase_index), 32'd5);

        // Tuning word accepted one cycle before a tick
        chk("hs_ready_idle", 32'(ftw_ready), 32'd1);
        ftw_valid = 1'b1;
        ftw_in    = 24'd65536;
        step();
        chk("hs_ready_pend", 32'(ftw_ready),     32'd0);
        chk("hs_no_strobe",  32'(sample_strobe), 32'd0);
        ftw_in = 24'd163840;
        step();
        ftw_valid = 1'b0;
        chk("hs_tick_strobe", 32'(sample_strobe), 32'd1);
        chk("hs_tick_idx",    32'(phase_index),   32'd6);
        chk("hs_ready_commit", 32'(ftw_ready),    32'd1);
        wait_strobe(12, n);
        chk("hs_idx_old_ftw", 32'(phase_index), 32'd7);
        wait_strobe(12, n);
        chk("hs_idx_new_ftw", 32'(phase_index), 32'd9);
        wait_strobe(12, n);
        chk("hs_idx_new_ftw2", 32'(phase_index), 32'd11);

        // Pending word committed by a clear that also beats a due tick
        ftw_valid = 1'b1;
        ftw_in    = 24'd32768;
        step();
        ftw_valid  = 1'b0;
        sync_clear = 1'b1;
        step();
        sync_clear = 1'b0;
        chk("clr_no_strobe", 32'(sample_strobe), 32'd0);
        chk("clr_index",     32'(phase_index),   32'd0);
        chk("clr_lut",       32'(lut_addr),      32'd0);
        chk("clr_mirror",    32'(mirror),        32'd0);
        chk("clr_negate",    32'(negate),        32'd0);
        chk("clr_ready",     32'(ftw_ready),     32'd1);
        div_in = 16'd1;
        for (int k = 0; k < 200; k++) begin
            wait_strobe(4, n);
            chk("clr_run_idx", 32'(phase_index), 32'(k));
        end
        chk("i199_lut",    32'(lut_addr), 32'd56);
        chk("i199_mirror", 32'(mirror),   32'd1);

        // Clear coincident with the tick that would show 200
        sync_clear = 1'b1;
        step();
        sync_clear = 1'b0;
        chk("sc200_no_strobe", 32'(sample_strobe), 32'd0);
        chk("sc200_index",     32'(phase_index),   32'd0);
        chk("sc200_mirror",    32'(mirror),        32'd0);
        step();
        chk("sc200_next_strobe", 32'(sample_strobe), 32'd1);
        chk("sc200_next_idx",    32'(phase_index),   32'd0);

        // Run dropped at index 77, then re-raised
        div_in = 16'd3;
        for (int k = 1; k <= 77; k++) begin
            wait_strobe(8, n);
            chk("div3_gap", 32'(n),           32'd3);
            chk("div3_idx", 32'(phase_index), 32'(k));
        end
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("stop_quiet", 32'(sample_strobe), 32'd0);
            chk("stop_hold",  32'(phase_index),   32'd77);
        end
        run = 1'b1;
        wait_strobe(12, n);
        chk("rerun_gap", 32'(n),           32'd4);
        chk("rerun_idx", 32'(phase_index), 32'd78);
        chk("rerun_lut", 32'(lut_addr),    32'd78);

        // Reset mid-run with an update pending
        ftw_valid = 1'b1;
        ftw_in    = 24'd163840;
        step();
        ftw_valid = 1'b0;
        chk("mr_ready_pend", 32'(ftw_ready), 32'd0);
        rst_n = 1'b0;
        step();
        chk("mr_strobe",  32'(sample_strobe), 32'd0);
        chk("mr_index",   32'(phase_index),   32'd0);
        chk("mr_lut",     32'(lut_addr),      32'd0);
        chk("mr_mirror",  32'(mirror),        32'd0);
        chk("mr_negate",  32'(negate),        32'd0);
        chk("mr_wrapped", 32'(wrapped),       32'd0);
        chk("mr_ready",   32'(ftw_ready),     32'd0);
        rst_n  = 1'b1;
        div_in = 16'd1;
        step();
        chk("mr_ready_rel",  32'(ftw_ready),     32'd1);
        chk("mr_lat_strobe", 32'(sample_strobe), 32'd0);
        step();
        chk("mr_first_strobe", 32'(sample_strobe), 32'd1);
        chk("mr_first_idx",    32'(phase_index),   32'd0);
        step();
        chk("mr_idx1", 32'(phase_index), 32'd1);
        step();
        chk("mr_idx2", 32'(phase_index), 32'd2);
        chk("mr_ready_end", 32'(ftw_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
